// File: rtl/and_gate_unit.sv
// and_gate_unit: combinational bitwise AND plus a registered shadow copy,
// a rising-edge pulse on the registered result and a saturating all-ones counter.
module and_gate_unit #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     y_q,
  output logic                 y_rise,
  output logic [CNT_WIDTH-1:0] hit_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic all_ones;
  logic y_q_all_ones;

  // y stays purely combinational so it works with no clock and ignores reset
  assign y            = a & b;
  assign all_ones     = &y;
  assign y_q_all_ones = &y_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_rise    <= 1'b0;
      hit_count <= '0;
    end else begin
      y_q    <= y;
      y_rise <= all_ones & ~y_q_all_ones;
      // counter sticks at its maximum instead of wrapping
      if (all_ones && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_and_gate_unit.sv
// tb_and_gate_unit: drives three and_gate_unit configurations with directed and
// randomized stimulus and checks every cycle against a behavioural model.
module tb_and_gate_unit;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       check_en;

  logic       a1, b1, a2, b2;
  logic [3:0] a4, b4;

  logic       y1, yq1, rise1;
  logic [7:0] cnt1;
  logic [3:0] y4, yq4;
  logic       rise4;
  logic [7:0] cnt4;
  logic       y2, yq2, rise2;
  logic [1:0] cnt2;

  int checks;
  int errors;

  // index 0: WIDTH=1/CNT_WIDTH=8, 1: WIDTH=4/CNT_WIDTH=8, 2: WIDTH=1/CNT_WIDTH=2
  logic [3:0] m_yq[3];
  logic       m_rise[3];
  int         m_hits[3];

  and_gate_unit #(.WIDTH(1), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
    .y(y1), .y_q(yq1), .y_rise(rise1), .hit_count(cnt1)
  );

  and_gate_unit #(.WIDTH(4), .CNT_WIDTH(8)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
    .y(y4), .y_q(yq4), .y_rise(rise4), .hit_count(cnt4)
  );

  and_gate_unit #(.WIDTH(1), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2),
    .y(y2), .y_q(yq2), .y_rise(rise2), .hit_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] cur_y(int i);
    case (i)
      0:       return {3'b000, a1 & b1};
      1:       return a4 & b4;
      default: return {3'b000, a2 & b2};
    endcase
  endfunction

  function automatic bit is_all(int i, logic [3:0] v);
    if (i == 1) return (v == 4'hF);
    return (v[0] == 1'b1);
  endfunction

  // the counter is the number of hits since reset, clipped at the counter's maximum
  function automatic logic [7:0] exp_count(int i);
    int lim;
    lim = (i == 2) ? 3 : 255;
    return 8'((m_hits[i] > lim) ? lim : m_hits[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_yq[i]   <= 4'h0;
        m_rise[i] <= 1'b0;
        m_hits[i] <= 0;
      end else begin
        m_yq[i]   <= cur_y(i);
        m_rise[i] <= is_all(i, cur_y(i)) && !is_all(i, m_yq[i]);
        m_hits[i] <= m_hits[i] + (is_all(i, cur_y(i)) ? 1 : 0);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic va1, input logic vb1,
                               input logic [3:0] va4, input logic [3:0] vb4,
                               input logic va2, input logic vb2);
    rst_n = rst;
    a1 = va1; b1 = vb1;
    a4 = va4; b4 = vb4;
    a2 = va2; b2 = vb2;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("u1.y",         {7'b0, y1},    {4'b0, cur_y(0)});
      checkOutput("u4.y",         {4'b0, y4},    {4'b0, cur_y(1)});
      checkOutput("u2.y",         {7'b0, y2},    {4'b0, cur_y(2)});
      checkOutput("u1.y_q",       {7'b0, yq1},   {4'b0, m_yq[0]});
      checkOutput("u4.y_q",       {4'b0, yq4},   {4'b0, m_yq[1]});
      checkOutput("u2.y_q",       {7'b0, yq2},   {4'b0, m_yq[2]});
      checkOutput("u1.y_rise",    {7'b0, rise1}, {7'b0, m_rise[0]});
      checkOutput("u4.y_rise",    {7'b0, rise4}, {7'b0, m_rise[1]});
      checkOutput("u2.y_rise",    {7'b0, rise2}, {7'b0, m_rise[2]});
      checkOutput("u1.hit_count", cnt1,          exp_count(0));
      checkOutput("u4.hit_count", cnt4,          exp_count(1));
      checkOutput("u2.hit_count", {6'b0, cnt2},  exp_count(2));
    end
  end

  initial begin
    int   exp_y_tt[4]   = '{0, 0, 0, 1};
    logic exp_yq1[6]    = '{1, 1, 1, 0, 0, 0};
    logic exp_rise1[6]  = '{1, 0, 0, 0, 0, 0};
    int   exp_cnt1[6]   = '{1, 2, 3, 3, 3, 3};
    int   exp_cnt2[6]   = '{1, 2, 3, 3, 3, 3};
    int   exp_cnt4[6]   = '{0, 1, 2, 3, 4, 5};
    logic exp_rise4[6]  = '{0, 1, 0, 0, 0, 0};
    logic [3:0] exp_yq4[6] = '{4'h8, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    clk_run  = 1'b0;

    // truth table with no clock running
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      #4;
      checkOutput("tt.y", {7'b0, y1}, 8'(exp_y_tt[i]));
      #1;
    end
    a1 = 1'b0; b1 = 1'bx;
    #4 checkOutput("x.zero_and_x", {7'b0, y1}, 8'b0000_0000);
    #1 a1 = 1'b1;
    #4 checkOutput("x.one_and_x", {7'b0, y1}, 8'b0000_000x);
    #1 a4 = 4'b1100; b4 = 4'b1010; b1 = 1'b0;
    #4 checkOutput("w4.y_comb", {4'b0, y4}, 8'h08);
    #1;

    // clocked reset
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.u1.y_q",       {7'b0, yq1},   8'h00);
    checkOutput("rst.u1.y_rise",    {7'b0, rise1}, 8'h00);
    checkOutput("rst.u1.hit_count", cnt1,          8'h00);
    checkOutput("rst.u4.y_q",       {4'b0, yq4},   8'h00);
    checkOutput("rst.u4.hit_count", cnt4,          8'h00);
    checkOutput("rst.u2.hit_count", {6'b0, cnt2},  8'h00);
    check_en = 1'b1;

    // directed: hold-high on u1, saturation on u2, partial vs full match on u4
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, exp_yq1[k], 1'b1,
                    (k == 0) ? 4'b1100 : 4'hF, (k == 0) ? 4'b1010 : 4'hF,
                    1'b1, 1'b1);
      @(negedge clk);
      #1;
      if (k == 0) checkOutput("dir.u4.y", {4'b0, y4}, 8'h08);
      checkOutput("dir.u1.y_q",       {7'b0, yq1},   {7'b0, exp_yq1[k]});
      checkOutput("dir.u1.y_rise",    {7'b0, rise1}, {7'b0, exp_rise1[k]});
      checkOutput("dir.u1.hit_count", cnt1,          8'(exp_cnt1[k]));
      checkOutput("dir.u2.hit_count", {6'b0, cnt2},  8'(exp_cnt2[k]));
      checkOutput("dir.u4.hit_count", cnt4,          8'(exp_cnt4[k]));
      checkOutput("dir.u4.y_rise",    {7'b0, rise4}, {7'b0, exp_rise4[k]});
      checkOutput("dir.u4.y_q",       {4'b0, yq4},   {4'b0, exp_yq4[k]});
    end

    // mid-operation reset with hit_count at 2
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); #1;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("mid.pre.hit_count", cnt1, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("mid.rst.y",         {7'b0, y1},    8'h01);
    checkOutput("mid.rst.y_q",       {7'b0, yq1},   8'h00);
    checkOutput("mid.rst.y_rise",    {7'b0, rise1}, 8'h00);
    checkOutput("mid.rst.hit_count", cnt1,          8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("mid.rel.hit_count", cnt1,          8'h01);
    checkOutput("mid.rel.y_rise",    {7'b0, rise1}, 8'h01);

    // randomized traffic, biased toward all-ones with occasional reset
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 29) != 0),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      @(negedge clk);
      #1;
    end

    check_en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
